eth_tx_framer: RTL



---
 rtl/eth_pkg.sv | 12 +
 rtl/eth_tx_framer_crc32_d8.sv | 18 +
 rtl/eth_tx_framer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet transmit framer.
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, ABORT
  } tx_state_t;
endpackage

// File: rtl/eth_tx_framer_crc32_d8.sv
// Byte-wide next-state function of the reflected IEEE 802.3 CRC-32.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, FCS and IFG,
// fed by a request/response FIFO whose answer arrives one cycle after s_ready.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  localparam logic [7:0]  PRE_N = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_N = 8'(IFG_CYCLES);
  localparam logic [7:0]  FCS_N = 8'd4;
  localparam logic [10:0] MIN_N = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_N = 11'(MAX_PAYLOAD);

  tx_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] count_q, count_d;
  logic        eof_q, eof_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        pend_last_q, pend_last_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_in, crc_out, fcs_word;
  logic [7:0]  crc_byte;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, er_q, er_d;
  logic        busy_q, busy_d, done_q, done_d, urun_q, urun_d;
  logic        start, after_payload, start_last;
  logic [7:0]  start_byte;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v >= MAX_N) ? MAX_N : v + 11'd1;
  endfunction

  // The SFD cycle folds in the first byte from the hold register; pad cycles fold in zero.
  assign crc_in   = (state_q == SFD) ? CRC_INIT : crc_q;
  assign crc_byte = (state_q == SFD) ? hold_q :
                    ((state_q == DATA) && !eof_q) ? s_data : 8'h00;
  assign fcs_word = ~crc_q;

  crc32_d8 u_crc (
    .crc_in  (crc_in),
    .data    (crc_byte),
    .crc_out (crc_out)
  );

  // In IDLE the request drops combinationally on the beat that starts a frame.
  assign s_ready = !rst &&
                   (((state_q == IDLE) && !pend_vld_q && !s_valid) ||
                    (((state_q == SFD) || (state_q == DATA) || (state_q == ABORT)) && !eof_q));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    count_d       = count_q;
    eof_d         = eof_q;
    pend_vld_d    = pend_vld_q;
    pend_data_d   = pend_data_q;
    pend_last_d   = pend_last_q;
    hold_d        = hold_q;
    crc_d         = crc_q;
    txd_d         = 8'h00;
    en_d          = 1'b0;
    er_d          = 1'b0;
    done_d        = 1'b0;
    urun_d        = 1'b0;
    start         = 1'b0;
    start_byte    = 8'h00;
    start_last    = 1'b0;
    after_payload = 1'b0;

    // A beat after the frame's s_last belongs to the next frame.
    if (s_valid && eof_q && (state_q != IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_data_d = s_data;
      pend_last_d = s_last;
    end

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          start      = 1'b1;
          start_byte = pend_data_q;
          start_last = pend_last_q;
        end else if (s_valid) begin
          start      = 1'b1;
          start_byte = s_data;
          start_last = s_last;
        end
      end
      PREAMBLE: begin
        en_d = 1'b1;
        if (cnt_q == PRE_N) begin
          state_d = SFD;
          txd_d   = SFD_BYTE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          txd_d = PREAMBLE_BYTE;
        end
      end
      SFD: begin
        en_d    = 1'b1;
        state_d = DATA;
        txd_d   = hold_q;
        count_d = 11'd1;
        crc_d   = crc_out;
      end
      DATA: begin
        en_d = 1'b1;
        if (eof_q) begin
          after_payload = 1'b1;
        end else if (s_valid) begin
          count_d = sat_inc(count_q);
          crc_d   = crc_out;
          eof_d   = s_last;
          if ((sat_inc(count_q) == MAX_N) && !s_last) begin
            state_d = ABORT;
            er_d    = 1'b1;
          end else begin
            txd_d = s_data;
          end
        end else begin
          urun_d  = 1'b1;
          state_d = ABORT;
          er_d    = 1'b1;
        end
      end
      PAD: begin
        en_d          = 1'b1;
        after_payload = 1'b1;
      end
      FCS: begin
        if (cnt_q == FCS_N) begin
          state_d = IFG;
          cnt_d   = 8'd1;
          done_d  = 1'b1;
        end else begin
          en_d  = 1'b1;
          txd_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d = cnt_q + 8'd1;
        end
      end
      IFG: begin
        if (cnt_q == IFG_N) begin
          if (pend_vld_q) begin
            start      = 1'b1;
            start_byte = pend_data_q;
            start_last = pend_last_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ABORT: begin
        en_d = 1'b1;
        er_d = 1'b1;
        if (s_valid && !eof_q) begin
          eof_d = s_last;
          if (s_last) begin
            state_d = IFG;
            cnt_d   = 8'd1;
            en_d    = 1'b0;
            er_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (after_payload) begin
      if (count_q < MIN_N) begin
        state_d = PAD;
        count_d = sat_inc(count_q);
        crc_d   = crc_out;
        txd_d   = 8'h00;
      end else begin
        state_d = FCS;
        cnt_d   = 8'd1;
        txd_d   = fcs_word[7:0];
      end
    end

    if (start) begin
      hold_d     = start_byte;
      eof_d      = start_last;
      pend_vld_d = 1'b0;
      count_d    = 11'd0;
      cnt_d      = 8'd1;
      txd_d      = PREAMBLE_BYTE;
      en_d       = 1'b1;
      state_d    = PREAMBLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      count_q    <= 11'd0;
      eof_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      txd_q      <= 8'h00;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      eof_q      <= eof_d;
      pend_vld_q <= pend_vld_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      er_q       <= er_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      urun_q     <= urun_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q      <= hold_d;
    crc_q       <= crc_d;
    pend_data_q <= pend_data_d;
    pend_last_q <= pend_last_d;
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = urun_q;
endmodule
